// File: rtl/alu_shift_sequencer_pkg.sv
// alu_pkg: shared widths, shift op encodings and sequencer state enum.
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int AMT_W = 4;
  typedef enum logic [1:0] {SHR_A = 2'b00, SHL_A = 2'b01, SHR_B = 2'b10, SHL_B = 2'b11} shift_op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} seq_state_e;
endpackage

// File: rtl/alu_shift_sequencer_if.sv
// alu_shift_sequencer_if: command, response and shift-unit signals of the shift sequencer.
interface alu_shift_sequencer_if #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int AMT_W = alu_pkg::AMT_W
);
  logic req_valid;
  logic req_ready;
  logic signed [DATA_W-1:0] req_a;
  logic signed [DATA_W-1:0] req_b;
  logic [1:0] req_op;
  logic [AMT_W-1:0] req_amt;
  logic signed [DATA_W-1:0] shift_a;
  logic signed [DATA_W-1:0] shift_b;
  logic [1:0] shift_fun;
  logic shift_en;
  logic signed [DATA_W-1:0] shift_out;
  logic shift_flag;
  logic rsp_valid;
  logic rsp_ready;
  logic signed [DATA_W-1:0] rsp_data;
  logic rsp_err;
  modport slave (
    input req_valid, req_a, req_b, req_op, req_amt, shift_out, shift_flag, rsp_ready,
    output req_ready, shift_a, shift_b, shift_fun, shift_en, rsp_valid, rsp_data, rsp_err
  );
  modport master (
    output req_valid, req_a, req_b, req_op, req_amt, shift_out, shift_flag, rsp_ready,
    input req_ready, shift_a, shift_b, shift_fun, shift_en, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer: drives the single-bit shift unit amt times, feeding each result back.
// Optional WAIT watchdog enabled by ALU_SHIFT_SEQ_TIMEOUT_EN.
module alu_shift_sequencer #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int AMT_W = alu_pkg::AMT_W
`ifdef ALU_SHIFT_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4
`endif
) (
  input logic clk,
  input logic rst,
  alu_shift_sequencer_if.slave bus
);
  import alu_pkg::*;
  seq_state_e state_q, state_d;
  logic signed [DATA_W-1:0] work_q, work_d;
  logic [1:0] op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic issue;
  logic done;
`ifdef ALU_SHIFT_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic err_q, err_d;
`endif
  assign issue = state_q == ISSUE;
  assign done = state_q == DONE;
  assign bus.req_ready = state_q == IDLE;
  assign bus.shift_en = issue;
  assign bus.shift_fun = issue ? op_q : 2'b00;
  assign bus.shift_a = (issue && !op_q[1]) ? work_q : '0;
  assign bus.shift_b = (issue && op_q[1]) ? work_q : '0;
  assign bus.rsp_valid = done;
  assign bus.rsp_data = done ? work_q : '0;
`ifdef ALU_SHIFT_SEQ_TIMEOUT_EN
  assign bus.rsp_err = done && err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    op_d = op_q;
    rem_d = rem_q;
`ifdef ALU_SHIFT_SEQ_TIMEOUT_EN
    wcnt_d = wcnt_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: if (bus.req_valid) begin
        work_d = bus.req_op[1] ? bus.req_b : bus.req_a;
        op_d = bus.req_op;
        rem_d = bus.req_amt;
        state_d = bus.req_amt == '0 ? DONE : ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef ALU_SHIFT_SEQ_TIMEOUT_EN
        wcnt_d = '0;
`endif
      end
      WAIT: if (bus.shift_flag) begin
        work_d = bus.shift_out;
        rem_d = rem_q - 1'b1;
        state_d = rem_q == AMT_W'(1) ? DONE : ISSUE;
      end
`ifdef ALU_SHIFT_SEQ_TIMEOUT_EN
      else if (wcnt_q == CW'(TIMEOUT_CYC - 1)) begin
        state_d = DONE;
        err_d = 1'b1;
      end else wcnt_d = wcnt_q + 1'b1;
`endif
      DONE: if (bus.rsp_ready) begin
        state_d = IDLE;
`ifdef ALU_SHIFT_SEQ_TIMEOUT_EN
        err_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      work_q <= '0;
      op_q <= '0;
      rem_q <= '0;
`ifdef ALU_SHIFT_SEQ_TIMEOUT_EN
      wcnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      op_q <= op_d;
      rem_q <= rem_d;
`ifdef ALU_SHIFT_SEQ_TIMEOUT_EN
      wcnt_q <= wcnt_d;
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_shift_sequencer.sv
// tb_alu_shift_sequencer: scoreboard bench with a registered single-bit shift unit model.
module tb_alu_shift_sequencer;
  import alu_pkg::*;
  typedef struct {logic [15:0] d; logic e;} exp_t;
  exp_t exp_q[$];
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int errors = 0;
  logic force_noflag = 0;
  logic [15:0] su_out = 0;
  logic su_flag = 0;
  int en_cnt = 0;
  int b2b_cnt = 0;
  int sa_nz = 0;
  logic prev_en = 0;
  always #5 clk = ~clk;
  alu_shift_sequencer_if bus();
  alu_shift_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.shift_out = su_out;
  assign bus.shift_flag = su_flag;
  always_ff @(posedge clk) begin
    su_flag <= bus.shift_en && !force_noflag;
    if (bus.shift_en)
      su_out <= bus.shift_fun == 2'b00 ? bus.shift_a >> 1 :
                bus.shift_fun == 2'b01 ? bus.shift_a << 1 :
                bus.shift_fun == 2'b10 ? bus.shift_b >> 1 : bus.shift_b << 1;
  end
  always_ff @(posedge clk) begin
    if (bus.shift_en) en_cnt <= en_cnt + 1;
    if (bus.shift_en && prev_en) b2b_cnt <= b2b_cnt + 1;
    if (bus.shift_a !== 16'h0) sa_nz <= sa_nz + 1;
    prev_en <= bus.shift_en;
  end
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op, input logic [3:0] amt);
    logic [15:0] v;
    v = op[1] ? b : a;
    for (int i = 0; i < 16; i++) if (i < int'(amt)) v = op[0] ? v << 1 : v >> 1;
    return v;
  endfunction
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op, input logic [3:0] amt,
                      input logic [15:0] ed, input logic ee, output int waits);
    exp_q.push_back('{ed, ee});
    bus.req_a = a;
    bus.req_b = b;
    bus.req_op = op;
    bus.req_amt = amt;
    bus.req_valid = 1;
    waits = 0;
    while (!bus.req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=%b required 1", bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    bus.req_a = 16'($urandom);
    bus.req_b = 16'($urandom);
    bus.req_op = 2'($urandom);
    bus.req_amt = 4'($urandom);
  endtask
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", bus.rsp_valid);
    end
  endtask
  task automatic handshake;
    bus.rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 0;
  endtask
  task automatic test_reset;
    rst = 0;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data: got %h required 0000", bus.rsp_data); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b required 0", bus.rsp_err); end
    checks++; if (bus.shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en: got %b required 0", bus.shift_en); end
    checks++; if ({bus.shift_a, bus.shift_b, bus.shift_fun} !== 34'h0) begin errors++; $display("FAIL reset_shift_bus: a=%h b=%h fun=%b required all 0", bus.shift_a, bus.shift_b, bus.shift_fun); end
    rst = 1;
    @(negedge clk);
  endtask
  task automatic test_amt0;
    int w, lat, e0;
    exp_t e;
    e0 = en_cnt;
    send(16'h1234, 16'h5555, SHL_A, 4'd0, 16'h1234, 1'b0, w);
    wait_rsp(lat);
    e = exp_q.pop_front();
    checks++; if (lat != 1) begin errors++; $display("FAIL amt0_latency: got %0d required 1", lat); end
    checks++; if (bus.rsp_data !== e.d) begin errors++; $display("FAIL amt0_data: got %h required %h", bus.rsp_data, e.d); end
    handshake();
    checks++; if (en_cnt - e0 != 0) begin errors++; $display("FAIL amt0_shift_en: got %0d pulses required 0", en_cnt - e0); end
  endtask
  task automatic test_shl4;
    int w, lat, e0, b0;
    exp_t e;
    e0 = en_cnt;
    b0 = b2b_cnt;
    send(16'h0001, 16'hFFFF, SHL_A, 4'd4, 16'h0010, 1'b0, w);
    wait_rsp(lat);
    e = exp_q.pop_front();
    checks++; if (lat != 9) begin errors++; $display("FAIL shl4_latency: got %0d required 9", lat); end
    checks++; if (bus.rsp_data !== e.d) begin errors++; $display("FAIL shl4_data: got %h required %h", bus.rsp_data, e.d); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL shl4_err: got %b required 0", bus.rsp_err); end
    handshake();
    checks++; if (en_cnt - e0 != 4) begin errors++; $display("FAIL shl4_pulses: got %0d required 4", en_cnt - e0); end
    checks++; if (b2b_cnt != b0) begin errors++; $display("FAIL shl4_en_consecutive: got %0d required %0d", b2b_cnt, b0); end
  endtask
  task automatic test_shr15_b;
    int w, lat, s0;
    exp_t e;
    s0 = sa_nz;
    send(16'h7777, 16'h8000, SHR_B, 4'd15, 16'h0001, 1'b0, w);
    wait_rsp(lat);
    e = exp_q.pop_front();
    checks++; if (lat != 31) begin errors++; $display("FAIL shr15_latency: got %0d required 31", lat); end
    checks++; if (bus.rsp_data !== e.d) begin errors++; $display("FAIL shr15_data: got %h required %h", bus.rsp_data, e.d); end
    handshake();
    checks++; if (sa_nz != s0) begin errors++; $display("FAIL shr15_shift_a_nonzero: got %0d cycles required 0", sa_nz - s0); end
  endtask
  task automatic test_back_to_back;
    int w, lat;
    exp_t e;
    send(16'h0003, 16'h0, SHL_A, 4'd2, 16'h000C, 1'b0, w);
    wait_rsp(lat);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== e.d || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b data=%h req_ready=%b required 1 %h 0", i, bus.rsp_valid, bus.rsp_data, bus.req_ready, e.d);
      end
      @(negedge clk);
    end
    handshake();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_after_rsp: req_ready=%b required 1", bus.req_ready); end
    send(16'h4000, 16'h0, SHR_A, 4'd3, 16'h0800, 1'b0, w);
    checks++; if (w != 0) begin errors++; $display("FAIL next_accept_wait: got %0d cycles required 0", w); end
    wait_rsp(lat);
    e = exp_q.pop_front();
    checks++; if (bus.rsp_data !== e.d) begin errors++; $display("FAIL next_data: got %h required %h", bus.rsp_data, e.d); end
    handshake();
  endtask
  task automatic test_reset_mid;
    int w, lat;
    exp_t e;
    send(16'h00FF, 16'h0, SHL_A, 4'd8, model(16'h00FF, 16'h0, SHL_A, 4'd8), 1'b0, w);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    void'(exp_q.pop_back());
    checks++; if (bus.req_ready !== 1'b1 || bus.shift_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req_ready=%b shift_en=%b rsp_valid=%b required 1 0 0", bus.req_ready, bus.shift_en, bus.rsp_valid);
    end
    send(16'h0, 16'h00F0, SHR_B, 4'd3, 16'h001E, 1'b0, w);
    wait_rsp(lat);
    e = exp_q.pop_front();
    checks++; if (bus.rsp_data !== e.d || lat != 7) begin errors++; $display("FAIL after_reset_cmd: data=%h lat=%0d required %h 7", bus.rsp_data, lat, e.d); end
    handshake();
  endtask
  task automatic test_random;
    int w, lat;
    logic [15:0] a, b;
    logic [1:0] op;
    logic [3:0] amt;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      op = 2'($urandom);
      amt = 4'($urandom);
      send(a, b, op, amt, model(a, b, op, amt), 1'b0, w);
      wait_rsp(lat);
      e = exp_q.pop_front();
      checks++;
      if (bus.rsp_data !== e.d || lat != 2 * int'(amt) + 1) begin
        errors++;
        $display("FAIL random[%0d] op=%b amt=%0d: data=%h lat=%0d required %h %0d", i, op, amt, bus.rsp_data, lat, e.d, 2 * int'(amt) + 1);
      end
      handshake();
    end
  endtask
`ifdef ALU_SHIFT_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int w, lat;
    exp_t e;
    force_noflag = 1;
    send(16'h1234, 16'h0, SHL_A, 4'd3, 16'h1234, 1'b1, w);
    wait_rsp(lat);
    e = exp_q.pop_front();
    checks++; if (lat != 6) begin errors++; $display("FAIL timeout_latency: got %0d required 6", lat); end
    checks++; if (bus.rsp_data !== e.d || bus.rsp_err !== e.e) begin errors++; $display("FAIL timeout_rsp: data=%h err=%b required %h %b", bus.rsp_data, bus.rsp_err, e.d, e.e); end
    handshake();
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b required 0", bus.rsp_err); end
    force_noflag = 0;
  endtask
`endif
  initial begin
    bus.req_valid = 0;
    bus.req_a = 0;
    bus.req_b = 0;
    bus.req_op = 0;
    bus.req_amt = 0;
    bus.rsp_ready = 0;
    test_reset();
    test_amt0();
    test_shl4();
    test_shr15_b();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef ALU_SHIFT_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
